// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the writeback stage and its register file.
// Contents:
//   wbState_e  - writeback sequencer states (RUN, ECALL_WAIT)
//   REG_*      - architectural register indices with a fixed role
package pipeline_pkg;

  typedef enum logic {
    RUN        = 1'b0,
    ECALL_WAIT = 1'b1
  } wbState_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd2;
  localparam logic [4:0] REG_A0   = 5'd10;
  localparam logic [4:0] REG_A7   = 5'd17;

endpackage

// File: rtl/reg_file.sv
// reg_file
// 32 x DATA_WIDTH architectural register file with one synchronous write
// port and two asynchronous read ports. x0 is hardwired to zero.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   we, waddr, wdata    - write port (writes to x0 are dropped)
//   raddr1/2, rdata1/2  - combinational read ports for decode
//   a0Val, a7Val        - fixed taps on x10/x17 for the ecall snapshot
// Parameters:
//   DATA_WIDTH - register width
//   STACK_INIT - reset value of x2 (sp)
module reg_file
  import pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] STACK_INIT = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [4:0]            raddr1,
  input  logic [4:0]            raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic [DATA_WIDTH-1:0] a0Val,
  output logic [DATA_WIDTH-1:0] a7Val
);

  logic [DATA_WIDTH-1:0] regs_q [32];

  // Reset loads the stack pointer and clears everything else; the write
  // port never touches x0 so its storage stays at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (5'(i) == REG_SP) ? STACK_INIT : '0;
      end
    end else if (we && (waddr != REG_ZERO)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // x0 is forced to zero on the read side as well.
  assign rdata1 = (raddr1 == REG_ZERO) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == REG_ZERO) ? '0 : regs_q[raddr2];
  assign a0Val  = regs_q[REG_A0];
  assign a7Val  = regs_q[REG_A7];

endmodule

// File: rtl/pipeline_writeback.sv
// pipeline_writeback
// Final pipeline stage: commits the memory stage's writeback bundle into the
// register file, serves decode's two read ports, and sequences ecalls
// through a request/done handshake with the system-call handler.
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   wb_enable, wb_dst_reg, wb_dst_val  - writeback bundle
//   ecall_wb                           - retiring instruction is an ecall
//   ready                              - bundle accepted (low during ecall)
//   rs1_addr/rs2_addr, rs1_val/rs2_val - decode read ports
//   ecall_req, ecall_a0, ecall_a7      - pending ecall and its x10/x17 snapshot
//   ecall_done, ecall_ret              - handler completion and return value
//   retired                            - committed instruction count
// Configuration macro:
//   WB_BYPASS_EN - forward the in-flight write to the read ports
module pipeline_writeback
  import pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] STACK_INIT = 64'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_enable,
  input  logic [4:0]            wb_dst_reg,
  input  logic [DATA_WIDTH-1:0] wb_dst_val,
  input  logic                  ecall_wb,
  output logic                  ready,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_val,
  output logic [DATA_WIDTH-1:0] rs2_val,
  output logic                  ecall_req,
  output logic [DATA_WIDTH-1:0] ecall_a0,
  output logic [DATA_WIDTH-1:0] ecall_a7,
  input  logic                  ecall_done,
  input  logic [DATA_WIDTH-1:0] ecall_ret,
  output logic [63:0]           retired
);

  wbState_e              state_q;
  logic                  ecallReq_q;
  logic [DATA_WIDTH-1:0] ecallA0_q;
  logic [DATA_WIDTH-1:0] ecallA7_q;
  logic [63:0]           retired_q;

  logic                  rfWe;
  logic [4:0]            rfWaddr;
  logic [DATA_WIDTH-1:0] rfWdata;
  logic [DATA_WIDTH-1:0] rfRd1;
  logic [DATA_WIDTH-1:0] rfRd2;
  logic [DATA_WIDTH-1:0] a0Tap;
  logic [DATA_WIDTH-1:0] a7Tap;
  logic [DATA_WIDTH-1:0] a0Post;
  logic [DATA_WIDTH-1:0] a7Post;

  // The single write port is shared: the bundle owns it in RUN, the ecall
  // return value owns it on the completing cycle of ECALL_WAIT.
  always_comb begin
    rfWe    = 1'b0;
    rfWaddr = wb_dst_reg;
    rfWdata = wb_dst_val;
    if (state_q == RUN) begin
      rfWe = wb_enable;
    end else if (ecall_done) begin
      rfWe    = 1'b1;
      rfWaddr = REG_A0;
      rfWdata = ecall_ret;
    end
  end

  reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .STACK_INIT (STACK_INIT)
  ) uRegFile (
    .clk    (clk),
    .reset  (reset),
    .we     (rfWe),
    .waddr  (rfWaddr),
    .wdata  (rfWdata),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rfRd1),
    .rdata2 (rfRd2),
    .a0Val  (a0Tap),
    .a7Val  (a7Tap)
  );

  // The ecall snapshot must include a write to x10/x17 retiring in the same
  // cycle, so the stored value is overridden by the bundle when it targets it.
  assign a0Post = (wb_enable && (wb_dst_reg == REG_A0)) ? wb_dst_val : a0Tap;
  assign a7Post = (wb_enable && (wb_dst_reg == REG_A7)) ? wb_dst_val : a7Tap;

  // Sequencer: an ecall is counted as retired on entry, and the handshake
  // holds the stage until the handler reports done. Reset wins over done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      ecallReq_q <= 1'b0;
      ecallA0_q  <= '0;
      ecallA7_q  <= '0;
      retired_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (wb_enable || ecall_wb) begin
            retired_q <= retired_q + 64'd1;
          end
          if (ecall_wb) begin
            ecallA0_q  <= a0Post;
            ecallA7_q  <= a7Post;
            ecallReq_q <= 1'b1;
            state_q    <= ECALL_WAIT;
          end
        end
        ECALL_WAIT: begin
          if (ecall_done) begin
            ecallReq_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  // Forward whatever the register file is about to commit this cycle, so a
  // dependent instruction in decode need not stall.
  always_comb begin
    rs1_val = rfRd1;
    rs2_val = rfRd2;
    if (rfWe && (rfWaddr != REG_ZERO)) begin
      if (rs1_addr == rfWaddr) rs1_val = rfWdata;
      if (rs2_addr == rfWaddr) rs2_val = rfWdata;
    end
  end
`else
  // Without forwarding decode sees only committed state and must stall on a
  // read-after-write hazard.
  assign rs1_val = rfRd1;
  assign rs2_val = rfRd2;
`endif

  assign ready     = (state_q == RUN);
  assign ecall_req = ecallReq_q;
  assign ecall_a0  = ecallA0_q;
  assign ecall_a7  = ecallA7_q;
  assign retired   = retired_q;

endmodule
